fifo_queue: RTL and testbench
=============================

// Module: fifo_queue
// PURPOSE
// - Synchronous show-ahead (first-word-fall-through) FIFO of N entries, each W bits wide.
// - Used by the CXU switch as a per-target queue of initiator IDs.
// - Each request accepted by a target pushes the issuing initiator's ID.
// - The head entry tells the switch which initiator owns the target's next response.
// - Popped when that response handshakes.
// PARAMETERS
// - W  default 8   entry width in bits; must be >= 1.
// - N  default 16  capacity in entries; must be >= 1; need not be a power of two.
// PORTS
// - clk      in   1  clock, rising edge; the only clock.
// - rst      in   1  reset; asynchronous, active-low.
// - clk_en   in   1  clock enable; when 0, all state holds.
// - i_valid  in   1  push request.
// - i_ready  out  1  space available (not full).
// - i        in   W  push data.
// - o_valid  out  1  head valid (not empty).
// - o_ready  in   1  pop request.
// - o        out  W  head data.
// BEHAVIOUR
// - State: storage mem[0..N-1], read pointer rd, write pointer wr, count cnt.
//   - rd and wr are $clog2(N) bits wide, minimum 1 bit.
//   - cnt is $clog2(N+1) bits wide.
// - Reset (rst==0, async, at any time):
//   - rd=0, wr=0, cnt=0.
//   - Therefore o_valid=0, i_ready=1, o='0 immediately; any in-flight contents are discarded.
//   - mem is not reset.
// - Combinational outputs, all functions of state only (no input-to-output paths):
//   - i_ready = (cnt != N)
//   - o_valid = (cnt != 0)
//   - o = o_valid ? mem[rd] : '0
// - push = i_valid & i_ready & clk_en. On push: mem[wr] <= i; wr <= (wr==N-1) ? 0 : wr+1.
// - pop = o_valid & o_ready & clk_en. On pop: rd <= (rd==N-1) ? 0 : rd+1.
// - cnt: +1 on push only; -1 on pop only; unchanged on both or neither.
// - Latency: an entry pushed at edge k is visible on o with o_valid=1 after edge k.
//   - It can be popped in the cycle following edge k.
// - Full (cnt==N):
//   - i_ready=0; i_valid is ignored even if a pop happens in the same cycle.
//   - Pop-then-refill therefore costs one cycle.
// - Empty (cnt==0):
//   - o_ready is ignored.
//   - A same-cycle push still happens; no bypass to o.
// - Simultaneous push and pop with 0<cnt<N: both occur, cnt unchanged, order preserved.
// - i_valid while full and o_ready while empty are legal: no state change, no error flag.
// - clk_en==0 freezes all state even if handshake inputs are asserted.
// - Order is strictly FIFO across pointer wrap-around.
// STRUCTURE
// - Single module with no sub-modules.
// - Storage is an unpacked reg array written only on push.
// - Pointer-increment-with-wrap may be a local function.
// - No shared package content needed; W and N are self-contained.
// - The optional clog2-with-minimum-1 helper belongs in common_pkg if not already present.
// TESTING
// - Reset check (W=4, N=4): assert rst=0 mid-run after 2 pushes.
//   - Require immediately o_valid=0, i_ready=1, o=0.
//   - After release, push 5 and require o=5.
// - Fill: push 1,2,3,4 on consecutive cycles.
//   - Require i_ready=0 after the 4th push and o=1.
//   - A 5th push of 9 is dropped; popping 4 times yields 1,2,3,4, then o_valid=0.
// - Simultaneous push/pop (N=4):
//   - Hold 2 entries {7,8}; in one cycle push 9 and pop.
//   - Require cnt stays 2 and the next pops give 8, then 9.
// - Wrap-around: 10 cycles of push(k)+pop with 1 entry resident.
//   - Require the output sequence to equal the input sequence delayed by one cycle.
//   - Pointers wrap with no loss or duplication.
// - Boundary rules:
//   - When full, assert push and pop in the same cycle: the pop occurs, the push is dropped, cnt=N-1.
//   - When empty, assert push and pop in the same cycle: cnt=1 and o=pushed value.
// - clk_en=0 with i_valid=1, o_ready=1 for 3 cycles: require no change in o, o_valid or i_ready.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// Shared helpers for the fifo_queue block.
package fifo_queue_pkg;

    // Index width for an N-entry array, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_queue.sv
// Show-ahead FIFO holding initiator IDs per switch target.
// The head entry is presented on o whenever the queue is non-empty.
module fifo_queue
    import fifo_queue_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [W-1:0] i,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o
);

    localparam int PW = clog2_min1(N);
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  mem [N];
    logic [PW-1:0] rd;
    logic [PW-1:0] wr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Pointer advance with wrap at N-1, so N need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags and head data depend on state only, never on the handshake inputs.
    always_comb begin
        i_ready = (cnt != CW'(N));
        o_valid = (cnt != '0);
        o       = o_valid ? mem[rd] : '0;
        push    = i_valid & i_ready & clk_en;
        pop     = o_valid & o_ready & clk_en;
    end

    // Storage is written only on an accepted push and is not cleared by reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= i;
    end

    // Pointers and occupancy; reset empties the queue and discards contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= ptr_inc(wr);
            if (pop)  rd <= ptr_inc(rd);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue at W=4, N=4.
module tb_fifo_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic [3:0] i = '0;
    logic       o_valid;
    logic       o_ready = 1'b0;
    logic [3:0] o;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_queue #(.W(4), .N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i       (i),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o       (o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock with the given handshake inputs; returns 1 time unit after the edge.
    task automatic step(input logic iv, input logic [3:0] d, input logic orr);
        i_valid = iv;
        i       = d;
        o_ready = orr;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b1;
        chk("rst_ovalid", 32'(o_valid), 0);
        chk("rst_iready", 32'(i_ready), 1);
        chk("rst_o",      32'(o),       0);

        // Async reset mid-run after two pushes
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        chk("pre_rst_o", 32'(o), 3);
        rst = 1'b0;
        #2;
        chk("async_rst_ovalid", 32'(o_valid), 0);
        chk("async_rst_iready", 32'(i_ready), 1);
        chk("async_rst_o",      32'(o),       0);
        rst = 1'b1;
        step(1'b1, 4'd5, 1'b0);
        chk("post_rst_o",      32'(o),       5);
        chk("post_rst_ovalid", 32'(o_valid), 1);
        step(1'b0, 4'd0, 1'b1);
        chk("post_rst_empty", 32'(o_valid), 0);

        // Fill to capacity, attempt an overflow push, then drain
        for (int k = 1; k <= 4; k++) step(1'b1, 4'(k), 1'b0);
        chk("full_iready", 32'(i_ready), 0);
        chk("full_head",   32'(o),       1);
        chk("full_cnt",    32'(dut.cnt), 4);
        step(1'b1, 4'd9, 1'b0);
        chk("overflow_cnt", 32'(dut.cnt), 4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_o", 32'(o), 32'(k));
            step(1'b0, 4'd0, 1'b1);
        end
        chk("drain_empty", 32'(o_valid), 0);

        // Simultaneous push and pop with two resident entries
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd9, 1'b1);
        chk("pp_cnt", 32'(dut.cnt), 2);
        chk("pp_o8",  32'(o),       8);
        step(1'b0, 4'd0, 1'b1);
        chk("pp_o9",  32'(o),       9);
        step(1'b0, 4'd0, 1'b1);
        chk("pp_empty", 32'(o_valid), 0);

        // Wrap-around: one resident entry, output trails input by one cycle
        step(1'b1, 4'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            chk("wrap_o", 32'(o), 32'(k - 1));
            step(1'b1, 4'(k), 1'b1);
            chk("wrap_cnt", 32'(dut.cnt), 1);
        end
        chk("wrap_last", 32'(o), 10);
        step(1'b0, 4'd0, 1'b1);
        chk("wrap_empty", 32'(o_valid), 0);

        // Full with push+pop: pop happens, push dropped
        for (int k = 1; k <= 4; k++) step(1'b1, 4'(k), 1'b0);
        step(1'b1, 4'hA, 1'b1);
        chk("fullpp_cnt",    32'(dut.cnt), 3);
        chk("fullpp_o",      32'(o),       2);
        chk("fullpp_iready", 32'(i_ready), 1);
        for (int k = 2; k <= 4; k++) begin
            chk("fullpp_drain", 32'(o), 32'(k));
            step(1'b0, 4'd0, 1'b1);
        end
        chk("fullpp_empty", 32'(o_valid), 0);

        // Empty with push+pop: push lands, pop ignored
        step(1'b1, 4'hC, 1'b1);
        chk("emptypp_cnt",    32'(dut.cnt), 1);
        chk("emptypp_o",      32'(o),       12);
        chk("emptypp_ovalid", 32'(o_valid), 1);

        // Clock enable low freezes everything
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'hD, 1'b1);
            chk("cen_o",      32'(o),       12);
            chk("cen_ovalid", 32'(o_valid), 1);
            chk("cen_iready", 32'(i_ready), 1);
            chk("cen_cnt",    32'(dut.cnt), 1);
        end
        clk_en = 1'b1;
        step(1'b0, 4'd0, 1'b1);
        chk("cen_after_pop", 32'(o_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
